pass_scheduler: RTL
===================

PASS_SCHEDULER -- requirements
Module: pass_scheduler

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, meaning width of all address and stride ports.
REQ-002 SHALL have parameter CNT_BITS, default 8, meaning width of tile counts and pass indices.
REQ-003 SHALL have one clock and synchronous active-high reset: clk, input, 1, rising-edge clock; rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports: start, input, 1, begin layer; abort, input, 1, cancel layer.
REQ-005 SHALL have ports: num_m, num_c, input, CNT_BITS each, output-channel tile count and input-channel tile count.
REQ-006 SHALL have ports: filter_base, ifmap_base, bias_base, opsum_base, input, ADDR_BITS each, layer base addresses.
REQ-007 SHALL have ports: filter_stride, ifmap_stride, bias_stride, opsum_stride, input, ADDR_BITS each, per-tile address strides.
REQ-008 SHALL have ports: pass_run, output, 1, level start to pass controller; pass_done, input, 1, pass controller done level.
REQ-009 SHALL have ports: bias_ipsum_sel, output, 1; filter_addr, ifmap_addr, bias_addr, opsum_addr, output, ADDR_BITS each, current-pass base addresses.
REQ-010 SHALL have ports: m_idx, c_idx, output, CNT_BITS each; busy, done, aborted, output, 1 each.

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN, FINISH; every output SHALL be registered.
REQ-012 IDLE: start=1 SHALL latch num_m, num_c and all four strides; SHALL set filter/ifmap/bias/opsum_addr to their bases and m_idx=c_idx=0.
REQ-013 IDLE: start=1 with num_m and num_c both nonzero SHALL go to RUN next cycle; num_m=0 or num_c=0 SHALL go to FINISH.
REQ-014 RUN: pass_run=1; SHALL go to DRAIN on the first cycle with pass_done=1.
REQ-015 DRAIN: pass_run=0; SHALL stay in DRAIN while pass_done=1.
REQ-016 DRAIN: with pass_done=0 and last pass (m_idx=num_m-1, c_idx=num_c-1), SHALL go to FINISH.
REQ-017 DRAIN: with pass_done=0 otherwise, SHALL advance indices and addresses and return to RUN in the same edge.
REQ-018 Loop order: c_idx inner, m_idx outer; total passes = num_m*num_c.
REQ-019 Each advance: filter_addr += filter_stride.
REQ-020 Advance within an m tile (c_idx < num_c-1): c_idx += 1; ifmap_addr += ifmap_stride.
REQ-021 Advance at c wrap: c_idx = 0; ifmap_addr = ifmap_base (latched); m_idx += 1; bias_addr += bias_stride; opsum_addr += opsum_stride.
REQ-022 Addresses SHALL be computed by accumulation only, with no multipliers; addition SHALL be modulo 2^ADDR_BITS, silent wrap.
REQ-023 bias_ipsum_sel SHALL equal 1 when c_idx=0, else 0; it and all address outputs SHALL be stable throughout RUN and DRAIN.
REQ-024 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-025 busy SHALL be 1 in RUN, DRAIN and FINISH.
REQ-026 start asserted while busy SHALL be ignored; input changes while busy SHALL have no effect.
REQ-027 abort=1 in RUN or DRAIN SHALL force pass_run=0 and go to IDLE next cycle, pulsing aborted=1 for one cycle, with no done pulse.
REQ-028 abort SHALL take priority over pass_done in the same cycle; abort in IDLE or FINISH SHALL be ignored.

Reset
REQ-029 rst=1 SHALL, from any state including mid-RUN, force IDLE next edge.
REQ-030 rst=1 SHALL clear pass_run, busy, done, aborted, bias_ipsum_sel, all addresses, m_idx and c_idx to 0.
REQ-031 After reset release, the block SHALL accept start on the first cycle.

Verification
REQ-032 num_m=2, num_c=3, filter_base=0x1000, filter_stride=0x40, ifmap_base=0x2000, ifmap_stride=0x100, bias_base=0x3000, bias_stride=0x10, opsum_base=0x4000, opsum_stride=0x80 -> six passes:
- (m,c) sequence: (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
- filter_addr: 0x1000..0x1140 in steps of 0x40.
- ifmap_addr: 0x2000, 0x2100, 0x2200, repeated.
- bias_addr: 0x3000 for m=0, 0x3010 for m=1; opsum_addr: 0x4000, 0x4080.
- bias_ipsum_sel=1 only on passes 0 and 3; one done pulse after the sixth DRAIN.
REQ-033 start with num_c=0 -> FINISH then done pulse two cycles after start; pass_run never asserted.
REQ-034 pass_done held high 5 cycles after pass_run drop -> stays in DRAIN 5 cycles; indices and addresses unchanged until pass_done=0.
REQ-035 filter_base=0xFFFF_FFC0, filter_stride=0x40, 1x2 passes -> second pass filter_addr=0x0000_0000.
REQ-036 abort during second pass -> pass_run=0 next cycle, aborted pulse, no done; new start works. rst mid-RUN -> all outputs 0 next edge.

Source files
------------

// File: rtl/pass_scheduler.sv
// Walks an m-outer / c-inner tile loop, handing one pass at a time to a pass controller via a run/done level handshake.
// Outputs are registered off the next state. Passes advance only after pass_done drops, and abort returns to IDLE on the next edge.
module pass_scheduler #(
    parameter int ADDR_BITS = 32,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_BITS-1:0]  num_m,
    input  logic [CNT_BITS-1:0]  num_c,
    input  logic [ADDR_BITS-1:0] filter_base,
    input  logic [ADDR_BITS-1:0] ifmap_base,
    input  logic [ADDR_BITS-1:0] bias_base,
    input  logic [ADDR_BITS-1:0] opsum_base,
    input  logic [ADDR_BITS-1:0] filter_stride,
    input  logic [ADDR_BITS-1:0] ifmap_stride,
    input  logic [ADDR_BITS-1:0] bias_stride,
    input  logic [ADDR_BITS-1:0] opsum_stride,
    output logic                 pass_run,
    input  logic                 pass_done,
    output logic                 bias_ipsum_sel,
    output logic [ADDR_BITS-1:0] filter_addr,
    output logic [ADDR_BITS-1:0] ifmap_addr,
    output logic [ADDR_BITS-1:0] bias_addr,
    output logic [ADDR_BITS-1:0] opsum_addr,
    output logic [CNT_BITS-1:0]  m_idx,
    output logic [CNT_BITS-1:0]  c_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t state, state_nxt;

    logic [CNT_BITS-1:0]  num_m_q;
    logic [CNT_BITS-1:0]  num_c_q;
    logic [ADDR_BITS-1:0] filter_stride_q;
    logic [ADDR_BITS-1:0] ifmap_stride_q;
    logic [ADDR_BITS-1:0] bias_stride_q;
    logic [ADDR_BITS-1:0] opsum_stride_q;
    logic [ADDR_BITS-1:0] ifmap_base_q;

    logic last_c;
    logic last_pass;
    logic take_start;
    logic take_abort;
    logic advance;

    assign last_c     = (c_idx == num_c_q - CNT_BITS'(1));
    assign last_pass  = last_c && (m_idx == num_m_q - CNT_BITS'(1));
    assign take_start = (state == IDLE) && start;
    assign take_abort = ((state == RUN) || (state == DRAIN)) && abort;
    assign advance    = (state == DRAIN) && !abort && !pass_done && !last_pass;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ((num_m != '0) && (num_c != '0)) ? RUN : FINISH;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (pass_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // pass_done must fall before the next pass may start
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!pass_done) begin
                    state_nxt = last_pass ? FINISH : RUN;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_run        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            bias_ipsum_sel  <= 1'b0;
            filter_addr     <= '0;
            ifmap_addr      <= '0;
            bias_addr       <= '0;
            opsum_addr      <= '0;
            m_idx           <= '0;
            c_idx           <= '0;
            num_m_q         <= '0;
            num_c_q         <= '0;
            filter_stride_q <= '0;
            ifmap_stride_q  <= '0;
            bias_stride_q   <= '0;
            opsum_stride_q  <= '0;
            ifmap_base_q    <= '0;
        end else begin
            pass_run <= (state_nxt == RUN);
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == FINISH);
            aborted  <= take_abort;
            if (take_start) begin
                num_m_q         <= num_m;
                num_c_q         <= num_c;
                filter_stride_q <= filter_stride;
                ifmap_stride_q  <= ifmap_stride;
                bias_stride_q   <= bias_stride;
                opsum_stride_q  <= opsum_stride;
                ifmap_base_q    <= ifmap_base;
                filter_addr     <= filter_base;
                ifmap_addr      <= ifmap_base;
                bias_addr       <= bias_base;
                opsum_addr      <= opsum_base;
                m_idx           <= '0;
                c_idx           <= '0;
                bias_ipsum_sel  <= 1'b1;
            end else if (advance) begin
                filter_addr <= filter_addr + filter_stride_q;
                if (last_c) begin
                    // new output tile: restart the ifmap walk and seed with bias again
                    c_idx          <= '0;
                    ifmap_addr     <= ifmap_base_q;
                    m_idx          <= m_idx + CNT_BITS'(1);
                    bias_addr      <= bias_addr + bias_stride_q;
                    opsum_addr     <= opsum_addr + opsum_stride_q;
                    bias_ipsum_sel <= 1'b1;
                end else begin
                    c_idx          <= c_idx + CNT_BITS'(1);
                    ifmap_addr     <= ifmap_addr + ifmap_stride_q;
                    bias_ipsum_sel <= 1'b0;
                end
            end
        end
    end

endmodule
